// File: rtl/vga_out_csc.sv
// vga_out_csc: video output colour-space converter.
// RGB -> YPbPr (BT.601 / BT.709) or RGB passthrough, with a fixed 3-clock
// latency on every path. The mode is switched only on the vsync leading edge,
// and each pipeline stage carries its own mode tag so a pixel never mixes
// coefficients from two modes. Syncs and DE are delay-matched to the data.
module vga_out_csc #(
  parameter int DW       = 8,
  parameter bit VS_POL   = 1'b1,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      mode,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            csync,
  input  logic            de,
  input  logic [3*DW-1:0] din,
  output logic [3*DW-1:0] dout,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            csync_o,
  output logic            de_o,
  output logic [1:0]      mode_cur
);

  localparam int PW = DW + 12;  // product width
  localparam int AW = DW + 14;  // accumulator width

  localparam logic signed [AW-1:0] ZERO_C = {AW{1'b0}};
  localparam logic signed [AW-1:0] RND_C  = AW'(11'd512);
  localparam logic signed [AW-1:0] OFS_C  = AW'(1'b1) << (DW + 9);
  localparam logic signed [AW-1:0] MAX_C  = AW'({DW{1'b1}});
  localparam logic [DW-1:0]        HALF_C = DW'(1'b1) << (DW - 1);

  // Coefficient table in 1/1024 units; idx = row*3 + col, rows Y/Pb/Pr, cols R/G/B.
  function automatic logic signed [11:0] coef(input logic [1:0] m, input logic [3:0] idx);
    logic signed [11:0] c;
    if (m == 2'd2) begin
      case (idx)
        4'd0:    c = 12'sd218;
        4'd1:    c = 12'sd732;
        4'd2:    c = 12'sd74;
        4'd3:    c = -12'sd117;
        4'd4:    c = -12'sd395;
        4'd5:    c = 12'sd512;
        4'd6:    c = 12'sd512;
        4'd7:    c = -12'sd465;
        4'd8:    c = -12'sd47;
        default: c = 12'sd0;
      endcase
    end else begin
      case (idx)
        4'd0:    c = 12'sd306;
        4'd1:    c = 12'sd601;
        4'd2:    c = 12'sd117;
        4'd3:    c = -12'sd173;
        4'd4:    c = -12'sd339;
        4'd5:    c = 12'sd512;
        4'd6:    c = 12'sd512;
        4'd7:    c = -12'sd429;
        4'd8:    c = -12'sd83;
        default: c = 12'sd0;
      endcase
    end
    return c;
  endfunction

  // Drop the 10 fraction bits and saturate into the unsigned component range.
  function automatic logic [DW-1:0] clamp(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] q;
    logic [DW-1:0]        r;
    q = a >>> 4'd10;
    if (q[AW-1]) begin
      r = {DW{1'b0}};
    end else if (q > MAX_C) begin
      r = {DW{1'b1}};
    end else begin
      r = q[DW-1:0];
    end
    return r;
  endfunction

  // Mode latch state
  logic                 vs_prev_q;
  logic [1:0]           mode_cur_q;
  logic                 vs_edge_s;
  logic [1:0]           mode_sel_s;

  // Stage 1
  logic signed [PW-1:0] comp_s [3];
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic [3*DW-1:0]      pass1_q;
  logic [1:0]           m1_q;
  logic [3:0]           sync1_q;

  // Stage 2
  logic signed [AW-1:0] acc_d [3];
  logic signed [AW-1:0] acc_q [3];
  logic [3*DW-1:0]      pass2_q;
  logic [1:0]           m2_q;
  logic [3:0]           sync2_q;

  // Stage 3
  logic [3*DW-1:0]      dout_d;
  logic [3*DW-1:0]      dout_q;
  logic [3:0]           sync3_q;

  assign vs_edge_s  = (vsync == VS_POL) && (vs_prev_q != VS_POL);
  assign mode_sel_s = (mode == 2'd3) ? 2'd0 : mode;

  // Vsync edge detect and frame-boundary mode latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q  <= ~VS_POL;
      mode_cur_q <= 2'd0;
    end else begin
      vs_prev_q  <= vsync;
      if (vs_edge_s) begin
        mode_cur_q <= mode_sel_s;
      end
    end
  end

  // Nine component x coefficient products using the mode applied this cycle.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      comp_s[c] = $signed({{12{1'b0}}, din[(2-c)*DW +: DW]});
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod_d[r*3+c] = comp_s[c] * PW'(coef(mode_cur_q, 4'(r*3+c)));
      end
    end
  end

  // Stage 1 registers: products, raw pixel, mode tag, syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= {PW{1'b0}};
      end
      pass1_q <= {3*DW{1'b0}};
      m1_q    <= 2'd0;
      sync1_q <= 4'd0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= prod_d[i];
      end
      pass1_q <= din;
      m1_q    <= mode_cur_q;
      sync1_q <= {hsync, vsync, csync, de};
    end
  end

  // Row sums with rounding term and chroma offset (no offset on Y).
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      acc_d[r] = AW'(prod_q[r*3]) + AW'(prod_q[r*3+1]) + AW'(prod_q[r*3+2])
               + RND_C + ((r == 0) ? ZERO_C : OFS_C);
    end
  end

  // Stage 2 registers: accumulators, raw pixel, mode tag, syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= {AW{1'b0}};
      end
      pass2_q <= {3*DW{1'b0}};
      m2_q    <= 2'd0;
      sync2_q <= 4'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
      end
      pass2_q <= pass1_q;
      m2_q    <= m1_q;
      sync2_q <= sync1_q;
    end
  end

  // Output select: passthrough or clamped {Pr,Y,Pb}, with optional blanking on de=0.
  always_comb begin
    dout_d = {3*DW{1'b0}};
    if (m2_q == 2'd0) begin
      if (BLANK_EN && !sync2_q[0]) begin
        dout_d = {3*DW{1'b0}};
      end else begin
        dout_d = pass2_q;
      end
    end else begin
      if (BLANK_EN && !sync2_q[0]) begin
        dout_d = {HALF_C, {DW{1'b0}}, HALF_C};
      end else begin
        dout_d = {clamp(acc_q[2]), clamp(acc_q[0]), clamp(acc_q[1])};
      end
    end
  end

  // Stage 3 registers drive the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= {3*DW{1'b0}};
      sync3_q <= 4'd0;
    end else begin
      dout_q  <= dout_d;
      sync3_q <= sync2_q;
    end
  end

  assign dout     = dout_q;
  assign hsync_o  = sync3_q[3];
  assign vsync_o  = sync3_q[2];
  assign csync_o  = sync3_q[1];
  assign de_o     = sync3_q[0];
  assign mode_cur = mode_cur_q;

endmodule

// File: tb/tb_vga_out_csc.sv
// Scoreboard bench for vga_out_csc: two instances (DW=8/VS_POL=1/BLANK_EN=1 and
// DW=10/VS_POL=0/BLANK_EN=0) driven every cycle; expectations come from an
// arithmetic reference model and are checked by a separate monitor.
module tb_vga_out_csc;

  typedef struct {
    int     due;
    longint dout;
    logic [3:0] sy;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [1:0]  mode0, mode1;
  logic        hs0, vs0, cs0, de0, hs1, vs1, cs1, de1;
  logic [23:0] din0, dout0;
  logic [29:0] din1, dout1;
  logic        hso0, vso0, cso0, deo0, hso1, vso1, cso1, deo1;
  logic [1:0]  mc0, mc1;

  exp_t q0[$], q1[$], mq0[$], mq1[$];
  int   cur0, cur1;
  bit   prev0, prev1;

  vga_out_csc #(.DW(8), .VS_POL(1'b1), .BLANK_EN(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .mode(mode0), .hsync(hs0), .vsync(vs0),
    .csync(cs0), .de(de0), .din(din0), .dout(dout0), .hsync_o(hso0),
    .vsync_o(vso0), .csync_o(cso0), .de_o(deo0), .mode_cur(mc0));

  vga_out_csc #(.DW(10), .VS_POL(1'b0), .BLANK_EN(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .mode(mode1), .hsync(hs1), .vsync(vs1),
    .csync(cs1), .de(de1), .din(din1), .dout(dout1), .hsync_o(hso1),
    .vsync_o(vso1), .csync_o(cso1), .de_o(deo1), .mode_cur(mc1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int fdiv1024(int x);
    if (x >= 0) return x / 1024;
    return -((-x + 1023) / 1024);
  endfunction

  function automatic int clampi(int x, int maxv);
    if (x < 0) return 0;
    if (x > maxv) return maxv;
    return x;
  endfunction

  // Reference pixel: m is the applied mode (0 RGB, 1 BT.601, 2 BT.709).
  function automatic longint ref_px(int dw, bit blank_en, int m, bit de, longint din);
    int maxv, half, r, g, b, y, pb, pr;
    int cy[3], cb[3], cr[3];
    longint mask;
    mask = (longint'(1) << (3*dw)) - 1;
    if (m == 0) begin
      if (blank_en && !de) return 0;
      return din & mask;
    end
    maxv = (1 << dw) - 1;
    half = 1 << (dw - 1);
    r = int'((din >> (2*dw)) & maxv);
    g = int'((din >> dw) & maxv);
    b = int'(din & maxv);
    if (m == 1) begin
      cy = '{306, 601, 117}; cb = '{-173, -339, 512}; cr = '{512, -429, -83};
    end else begin
      cy = '{218, 732, 74};  cb = '{-117, -395, 512}; cr = '{512, -465, -47};
    end
    y  = clampi(fdiv1024(cy[0]*r + cy[1]*g + cy[2]*b + 512), maxv);
    pb = clampi(fdiv1024(cb[0]*r + cb[1]*g + cb[2]*b + half*1024 + 512), maxv);
    pr = clampi(fdiv1024(cr[0]*r + cr[1]*g + cr[2]*b + half*1024 + 512), maxv);
    if (blank_en && !de) begin
      y = 0; pb = half; pr = half;
    end
    return (longint'(pr) << (2*dw)) | (longint'(y) << dw) | longint'(pb);
  endfunction

  // Issue one cycle of stimulus (inputs already set) and record expectations.
  task automatic tick();
    exp_t e;
    bit act;
    e.due = cyc + 3; e.dout = ref_px(8, 1'b1, cur0, de0, longint'(din0));
    e.sy = {hs0, vs0, cs0, de0}; q0.push_back(e);
    act = (vs0 == 1'b1);
    if (act && !prev0) cur0 = (mode0 == 2'd3) ? 0 : int'(mode0);
    prev0 = act;
    e.due = cyc + 1; e.dout = cur0; e.sy = 4'd0; mq0.push_back(e);

    e.due = cyc + 3; e.dout = ref_px(10, 1'b0, cur1, de1, longint'(din1));
    e.sy = {hs1, vs1, cs1, de1}; q1.push_back(e);
    act = (vs1 == 1'b0);
    if (act && !prev1) cur1 = (mode1 == 2'd3) ? 0 : int'(mode1);
    prev1 = act;
    e.due = cyc + 1; e.dout = cur1; e.sy = 4'd0; mq1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_dout0"}, longint'(dout0), 0);
    check({tag, "_sync0"}, longint'({hso0, vso0, cso0, deo0}), 0);
    check({tag, "_mode0"}, longint'(mc0), 0);
    check({tag, "_dout1"}, longint'(dout1), 0);
    check({tag, "_sync1"}, longint'({hso1, vso1, cso1, deo1}), 0);
    check({tag, "_mode1"}, longint'(mc1), 0);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); mq0.delete(); mq1.delete();
    cur0 = 0; cur1 = 0; prev0 = 1'b0; prev1 = 1'b0;
  endtask

  task automatic randomize_inputs();
    din0 = 24'($urandom()); din1 = 30'($urandom());
    mode0 = 2'($urandom_range(3)); mode1 = 2'($urandom_range(3));
    {hs0, cs0, hs1, cs1} = 4'($urandom());
    de0 = ($urandom_range(3) != 0); de1 = ($urandom_range(3) != 0);
  endtask

  // Monitor: compare DUT outputs against the scoreboard entries due this cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        check("u0_dout", longint'(dout0), e.dout);
        check("u0_sync", longint'({hso0, vso0, cso0, deo0}), longint'(e.sy));
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        check("u1_dout", longint'(dout1), e.dout);
        check("u1_sync", longint'({hso1, vso1, cso1, deo1}), longint'(e.sy));
      end
      if (mq0.size() > 0 && mq0[0].due == cyc) begin
        e = mq0.pop_front();
        check("u0_mode_cur", longint'(mc0), e.dout);
      end
      if (mq1.size() > 0 && mq1[0].due == cyc) begin
        e = mq1.pop_front();
        check("u1_mode_cur", longint'(mc1), e.dout);
      end
    end
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    randomize_inputs();
    vs0 = 1'b1; vs1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");

    // Release with both vsyncs inactive.
    vs0 = 1'b0; vs1 = 1'b1; mode0 = 2'd0; mode1 = 2'd0;
    de0 = 1'b1; de1 = 1'b1; hs0 = 1'b0; cs0 = 1'b0; hs1 = 1'b0; cs1 = 1'b0;
    reset_n = 1'b1;

    // Passthrough with exact 3-cycle alignment of data and syncs.
    din0 = 24'h123456; hs0 = 1'b1; tick();
    hs0 = 1'b0; din0 = 24'h000000; tick(); tick();

    // Latch BT.601 and check the reference colours.
    mode0 = 2'd1; vs0 = 1'b1; tick();
    mode0 = 2'd0;
    din0 = 24'hFFFFFF; tick();
    din0 = 24'hFF0000; tick();
    din0 = 24'h00FF00; tick();
    vs0 = 1'b0; tick();

    // Mid-frame request for BT.709 is ignored until the next leading edge.
    mode0 = 2'd2; din0 = 24'hFF0000; tick(); tick();
    vs0 = 1'b1; din0 = 24'hFF0000; tick();
    vs0 = 1'b0; din0 = 24'hFF0000; tick();
    din0 = 24'h0000FF; tick();

    // Blanking in YPbPr and in RGB (mode 3 treated as passthrough).
    mode0 = 2'd1; vs0 = 1'b1; de0 = 1'b1; tick();
    de0 = 1'b0; din0 = 24'hFFFFFF; tick();
    vs0 = 1'b0; tick();
    mode0 = 2'd3; vs0 = 1'b1; tick();
    de0 = 1'b0; din0 = 24'hFFFFFF; tick();
    vs0 = 1'b0; de0 = 1'b1; tick();

    // Active-low vsync instance: latch only on the 1->0 transition.
    mode1 = 2'd1; din1 = 30'h3FFFFFFF; tick();
    vs1 = 1'b0; tick();
    mode1 = 2'd2; tick();
    vs1 = 1'b1; tick();
    de1 = 1'b0; tick();
    de1 = 1'b1; mode1 = 2'd2; vs1 = 1'b0; tick();
    din1 = 30'h3FF00000; tick(); tick();

    // Randomised traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      if ($urandom_range(15) == 0) vs0 = ~vs0;
      if ($urandom_range(15) == 0) vs1 = ~vs1;
      if (i == 700) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset("rst_hold");
        reset_n = 1'b1;
      end
      tick();
    end

    // Drain and verify that every expected pixel was observed.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_u0", longint'(q0.size() + mq0.size()), 0);
    check("drain_u1", longint'(q1.size() + mq1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
